multilane_serializer: RTL and testbench
=======================================

Name: multilane_serializer

Overview:
- Parametrised successor of the single-lane frame serializer.
- Accepts frames of up to DATA_DEPTH words over a valid/ready handshake and stripes the words round-robin across NUM_LANES serial lanes.
- Supports selectable bit order and a per-frame programmable bit period.
- A one-frame holding buffer allows back-to-back frames with no idle bit period between them.
- Sits between the FEC encoder output packer and the lane PHY pads.

Parameters:
- DATA_WIDTH, 32, maximum bits per word.
- DATA_DEPTH, 4, maximum words per frame.
- DIV_WIDTH, 8, width of the bit-period divider.
- NUM_LANES, 2, number of serial output lanes (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  frame offered.
- in_ready  out  1  holding buffer free.
- in_data  in  [DATA_DEPTH-1:0][DATA_WIDTH-1:0]  frame words; word 0 is first.
- cfg_div  in  DIV_WIDTH  bit period minus 1, in clk cycles.
- cfg_width  in  $clog2(DATA_WIDTH)+1  bits per word minus 1.
- cfg_depth  in  $clog2(DATA_DEPTH)+1  words per frame minus 1.
- cfg_msb_first  in  1  0 = LSB first, 1 = MSB first.
- abort  in  1  synchronous drop of active and held frames.
- serial_out  out  NUM_LANES  lane data.
- serial_en  out  NUM_LANES  lane carries a valid bit.
- frame_start  out  1  pulse coincident with the first bit of a frame.
- done  out  1  pulse after the last bit period of a frame.
- busy  out  1  frame active.
- bit_count  out  $clog2(DATA_WIDTH)+1  current bit index within the word.
- slot_count  out  $clog2(DATA_DEPTH)+1  current slot index.

Behaviour:
- Reset values: serial_out=0, serial_en=0, frame_start=0, done=0, busy=0, bit_count=0, slot_count=0.
- in_ready = !hold_valid && !abort. It is 1 after reset.
- Accept occurs when in_valid && in_ready at a clk edge. On accept, the hold buffer latches in_data and all cfg_* inputs.
- Config is per frame; changing cfg_* mid-frame has no effect on the frame in progress.
- Saturation: cfg_width > DATA_WIDTH-1 is treated as DATA_WIDTH-1. cfg_depth > DATA_DEPTH-1 is treated as DATA_DEPTH-1.
- States:
  - IDLE: if hold_valid, load the active frame from hold, clear hold, go to SHIFT.
  - SHIFT: shift bits until the last bit of the last slot completes. Then, if hold_valid, load the next frame on the same edge (no gap); else go to IDLE.
- Latency: accept at edge T, load at edge T+1. From T+1: frame_start=1 for one cycle, and serial_out/serial_en present slot 0, bit 0.
- Bit period: each bit is held for cfg_div+1 cycles. cfg_div=0 gives one bit per clk.
- Slots: nslots = ceil((depth+1)/NUM_LANES). In slot s, lane L carries word s*NUM_LANES+L. serial_en[L]=1 only if that index ≤ depth; otherwise serial_en[L]=0 and serial_out[L]=0 for the whole slot.
- Bit selection: bit b of the word when LSB first; bit (width-b) when MSB first. bit_count runs 0..width, then wraps to 0 and increments slot_count.
- Frame end: done pulses one cycle, on the cycle after the final bit period ends.
  - Back-to-back: done coincides with frame_start of the next frame, and serial_en stays high on the used lanes.
  - Otherwise serial_en drops to 0 in that same cycle and busy drops.
- abort: at the next edge, clears active and hold state and all counters, forces serial_en=0, goes to IDLE. No done pulse.
  - abort wins over a simultaneous in_valid; that frame is not accepted.
- Asynchronous reset mid-frame: immediately returns all outputs to reset values; the held frame is lost.
- busy=1 in SHIFT.

Decomposition:
- Package ser_pkg holds:
  - state_t (S_IDLE, S_SHIFT)
  - a function computing nslots from depth and NUM_LANES
  - cfg saturation helpers
- Sub-module ser_bit_timer: a DIV_WIDTH down-counter producing a one-cycle bit_tick every cfg_div+1 cycles. It restarts on load and on abort.

Test Plan:
- NUM_LANES=2, div=0, width=7, depth=3, LSB first, words 0x01,0x80,0xFF,0x00 → lane0 outputs 0x01 then 0xFF, lane1 outputs 0x80 then 0x00, LSB first. frame_start at T+1; done 16 cycles later.
- depth=2 (3 words), NUM_LANES=2 → in slot 1, serial_en[1]=0 for 8 bit periods while lane0 sends word 2.
- div=3, msb_first=1, width=3, word 0xA on lane0 → serial_out[0] = 1,0,1,0, each bit held 4 cycles.
- Two frames offered back-to-back with in_valid held → in_ready drops after the first accept and rises on the load edge. No cycle with serial_en=0 between frames; done and frame_start coincide.
- abort asserted mid-slot 0 with a held frame and in_valid=1 → serial_en=0 next cycle, no done, in_ready=0 during abort, idle afterwards with nothing pending.
- cfg_width=63 with DATA_WIDTH=32 → 32 bits per word are shifted; rst_n pulsed mid-frame → all outputs zero immediately and in_ready=1.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and helpers for the multi-lane frame serializer.
package ser_pkg;

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;

  // Number of lane-parallel slots needed to carry depth+1 words.
  function automatic int unsigned calc_nslots(int unsigned depth, int unsigned lanes);
    return (depth + lanes) / lanes;
  endfunction

  function automatic int unsigned sat_cfg(int unsigned val, int unsigned max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period timer: one-cycle bit_tick at the last cycle of every div+1 cycle period.
module ser_bit_timer #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 clear,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign bit_tick = run && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (restart || bit_tick) begin
      cnt_d = div;
    end else if (run) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multilane_serializer.sv
// Frame serializer striping words round-robin over NUM_LANES lanes, with a one-frame
// holding buffer so consecutive frames run without an idle bit period.
module multilane_serializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned NUM_LANES  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic [DIV_WIDTH-1:0]                   cfg_div,
  input  logic [$clog2(DATA_WIDTH):0]            cfg_width,
  input  logic [$clog2(DATA_DEPTH):0]            cfg_depth,
  input  logic                                   cfg_msb_first,
  input  logic                                   abort,
  output logic [NUM_LANES-1:0]                   serial_out,
  output logic [NUM_LANES-1:0]                   serial_en,
  output logic                                   frame_start,
  output logic                                   done,
  output logic                                   busy,
  output logic [$clog2(DATA_WIDTH):0]            bit_count,
  output logic [$clog2(DATA_DEPTH):0]            slot_count
);

  localparam int unsigned WW = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned DW = $clog2(DATA_DEPTH) + 1;

  typedef logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] frame_t;

  state_t               state_q, state_d;
  logic                 hold_valid_q, hold_valid_d;
  frame_t               hold_data_q, act_data_q;
  logic [DIV_WIDTH-1:0] hold_div_q, act_div_q;
  logic [WW-1:0]        hold_width_q, act_width_q;
  logic [DW-1:0]        hold_depth_q, act_depth_q, act_last_slot_q;
  logic                 hold_msb_q, act_msb_q;
  logic [WW-1:0]        bit_q, bit_d;
  logic [DW-1:0]        slot_q, slot_d;
  logic                 frame_start_q, frame_start_d;
  logic                 done_q, done_d;
  logic                 accept, load, bit_tick;

  assign in_ready = !hold_valid_q && !abort;
  assign accept   = in_valid && in_ready;

  ser_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (load),
    .clear    (abort),
    .run      (state_q == S_SHIFT),
    .div      (load ? hold_div_q : act_div_q),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d       = state_q;
    hold_valid_d  = hold_valid_q;
    bit_d         = bit_q;
    slot_d        = slot_q;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
    load          = 1'b0;
    if (abort) begin
      state_d      = S_IDLE;
      hold_valid_d = 1'b0;
      bit_d        = '0;
      slot_d       = '0;
    end else begin
      if (accept) hold_valid_d = 1'b1;
      case (state_q)
        S_IDLE: load = hold_valid_q;
        S_SHIFT: begin
          if (bit_tick) begin
            if (bit_q == act_width_q) begin
              bit_d = '0;
              if (slot_q == act_last_slot_q) begin
                done_d = 1'b1;
                slot_d = '0;
                load   = hold_valid_q;
                if (!hold_valid_q) state_d = S_IDLE;
              end else begin
                slot_d = slot_q + DW'(1);
              end
            end else begin
              bit_d = bit_q + WW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Loading from hold also covers the back-to-back case on the final edge.
      if (load) begin
        hold_valid_d  = 1'b0;
        state_d       = S_SHIFT;
        bit_d         = '0;
        slot_d        = '0;
        frame_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hold_valid_q  <= 1'b0;
      bit_q         <= '0;
      slot_q        <= '0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      bit_q         <= bit_d;
      slot_q        <= slot_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q     <= '0;
      hold_div_q      <= '0;
      hold_width_q    <= '0;
      hold_depth_q    <= '0;
      hold_msb_q      <= 1'b0;
      act_data_q      <= '0;
      act_div_q       <= '0;
      act_width_q     <= '0;
      act_depth_q     <= '0;
      act_last_slot_q <= '0;
      act_msb_q       <= 1'b0;
    end else begin
      if (accept) begin
        hold_data_q  <= in_data;
        hold_div_q   <= cfg_div;
        hold_width_q <= WW'(sat_cfg(32'(cfg_width), DATA_WIDTH - 1));
        hold_depth_q <= DW'(sat_cfg(32'(cfg_depth), DATA_DEPTH - 1));
        hold_msb_q   <= cfg_msb_first;
      end
      if (load) begin
        act_data_q      <= hold_data_q;
        act_div_q       <= hold_div_q;
        act_width_q     <= hold_width_q;
        act_depth_q     <= hold_depth_q;
        act_last_slot_q <= DW'(calc_nslots(32'(hold_depth_q), NUM_LANES) - 1);
        act_msb_q       <= hold_msb_q;
      end
    end
  end

  // Lane L in slot s carries word s*NUM_LANES+L; lanes past the frame depth stay quiet.
  always_comb begin
    int idx;
    int sel;
    logic [DATA_WIDTH-1:0] word;
    serial_out = '0;
    serial_en  = '0;
    idx        = 0;
    word       = '0;
    sel        = act_msb_q ? int'(act_width_q) - int'(bit_q) : int'(bit_q);
    if (state_q == S_SHIFT) begin
      for (int l = 0; l < int'(NUM_LANES); l++) begin
        idx  = int'(slot_q) * int'(NUM_LANES) + l;
        word = '0;
        if (idx <= int'(act_depth_q)) begin
          serial_en[l] = 1'b1;
          for (int w = 0; w < int'(DATA_DEPTH); w++) begin
            if (w == idx) word = act_data_q[w];
          end
          for (int b = 0; b < int'(DATA_WIDTH); b++) begin
            if (b == sel) serial_out[l] = word[b];
          end
        end
      end
    end
  end

  assign busy        = (state_q == S_SHIFT);
  assign bit_count   = bit_q;
  assign slot_count  = slot_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_multilane_serializer.sv
// Scoreboard bench for multilane_serializer: stimulus pushes expected per-cycle lane records,
// a negedge monitor pops and compares whenever the DUT shows lane activity or a pulse.
module tb_multilane_serializer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][31:0] in_data;
  logic [7:0]       cfg_div;
  logic [5:0]       cfg_width;
  logic [2:0]       cfg_depth;
  logic             cfg_msb_first;
  logic             abort;
  logic [1:0]       serial_out;
  logic [1:0]       serial_en;
  logic             frame_start;
  logic             done;
  logic             busy;
  logic [5:0]       bit_count;
  logic [2:0]       slot_count;

  multilane_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .cfg_div      (cfg_div),
    .cfg_width    (cfg_width),
    .cfg_depth    (cfg_depth),
    .cfg_msb_first(cfg_msb_first),
    .abort        (abort),
    .serial_out   (serial_out),
    .serial_en    (serial_en),
    .frame_start  (frame_start),
    .done         (done),
    .busy         (busy),
    .bit_count    (bit_count),
    .slot_count   (slot_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] en;
    logic [1:0] out;
    logic       fs;
    logic       dn;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fs_cyc = 0;
  int   done_cyc = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected lane activity for one frame, one record per clk cycle, plus the trailing done cycle.
  function automatic void push_frame(input logic [3:0][31:0] d, input int div, input int width,
                                     input int depth, input bit msb, input bit b2b);
    int   w;
    int   dp;
    int   ns;
    int   idx;
    bit   first;
    rec_t r;
    w     = (width > 31) ? 31 : width;
    dp    = (depth > 3) ? 3 : depth;
    ns    = (dp + 2) / 2;
    first = 1'b1;
    if (b2b && q.size() > 0) void'(q.pop_back());
    for (int s = 0; s < ns; s++) begin
      for (int b = 0; b <= w; b++) begin
        for (int c = 0; c <= div; c++) begin
          r = '0;
          for (int l = 0; l < 2; l++) begin
            idx = s * 2 + l;
            if (idx <= dp) begin
              r.en[l]  = 1'b1;
              r.out[l] = d[idx][msb ? (w - b) : b];
            end
          end
          r.fs  = first;
          r.dn  = first && b2b;
          first = 1'b0;
          q.push_back(r);
        end
      end
    end
    r    = '0;
    r.dn = 1'b1;
    q.push_back(r);
  endfunction

  always @(negedge clk) begin
    rec_t e;
    rec_t g;
    if (rst_n && frame_start) fs_cyc = cyc;
    if (rst_n && done) done_cyc = cyc;
    if (rst_n && mon_on && (serial_en != 2'b00 || frame_start || done)) begin
      g = '{en: serial_en, out: serial_out, fs: frame_start, dn: done};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%0h exp=none", g);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL sb_lane got=en%b/out%b/fs%b/dn%b exp=en%b/out%b/fs%b/dn%b",
                   g.en, g.out, g.fs, g.dn, e.en, e.out, e.fs, e.dn);
        end
      end
    end
  end

  // Drive a frame from a negedge; returns just after the accepting posedge.
  task automatic offer(input logic [3:0][31:0] d, input int div, input int width, input int depth,
                       input bit msb);
    int n;
    in_data       = d;
    cfg_div       = 8'(div);
    cfg_width     = 6'(width);
    cfg_depth     = 3'(depth);
    cfg_msb_first = msb;
    in_valid      = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("offer_ready", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 20);
    check("fs_seen", frame_start, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0][31:0] d;
    logic [3:0][31:0] d2;
    logic [15:0]      seq;
    int               acc_cyc;
    int               bad;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_div = '0; cfg_width = '0;
    cfg_depth = '0; cfg_msb_first = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_serial_out", serial_out, 0);
    check("rst_serial_en", serial_en, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_slot_count", slot_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Four bytes over two lanes, LSB first, one bit per clk.
    mon_on = 1'b1;
    d = '{32'h00, 32'hFF, 32'h80, 32'h01};
    offer(d, 0, 7, 3, 1'b0);
    push_frame(d, 0, 7, 3, 1'b0, 1'b0);
    #1 in_valid = 1'b0;
    acc_cyc = cyc;
    drain();
    check("t1_fs_latency", fs_cyc - acc_cyc, 1);
    check("t1_done_delay", done_cyc - fs_cyc, 16);

    // Three words: lane1 idle during slot 1.
    d = '{32'h0, 32'h5A, 32'hC3, 32'h96};
    @(negedge clk);
    offer(d, 0, 7, 2, 1'b0);
    push_frame(d, 0, 7, 2, 1'b0, 1'b0);
    #1 in_valid = 1'b0;
    drain();
    check("t2_done_delay", done_cyc - fs_cyc, 16);

    // MSB first, 4-bit word 0xA, each bit held 4 clks.
    d = '{32'h0, 32'h0, 32'h0, 32'hA};
    @(negedge clk);
    offer(d, 3, 3, 0, 1'b1);
    push_frame(d, 3, 3, 0, 1'b1, 1'b0);
    #1 in_valid = 1'b0;
    wait_fs();
    seq = '0;
    for (int i = 0; i < 16; i++) begin
      seq = {seq[14:0], serial_out[0]};
      @(negedge clk);
    end
    check("t3_msb_seq", seq, 16'hF0F0);
    drain();
    check("t3_done_delay", done_cyc - fs_cyc, 16);

    // Back-to-back frames with in_valid held.
    d  = '{32'h33, 32'hCC, 32'h0F, 32'hA5};
    d2 = '{32'h0, 32'h0, 32'h9, 32'h6};
    @(negedge clk);
    offer(d, 0, 7, 3, 1'b0);
    push_frame(d, 0, 7, 3, 1'b0, 1'b0);
    #1 in_data = d2; cfg_width = 6'd3; cfg_depth = 3'd1;
    @(negedge clk);
    check("t4_ready_drop", in_ready, 0);
    @(negedge clk);
    check("t4_ready_rise", in_ready, 1);
    @(posedge clk);
    push_frame(d2, 0, 3, 1, 1'b0, 1'b1);
    #1 in_valid = 1'b0;
    drain();
    check("t4_done_fs_coincide", done_cyc - fs_cyc, 4);

    // Abort mid-slot 0 with a held frame and in_valid asserted.
    mon_on = 1'b0;
    d = '{32'h11, 32'h22, 32'h44, 32'h88};
    @(negedge clk);
    offer(d, 0, 7, 3, 1'b0);
    #1 in_valid = 1'b0;
    wait_fs();
    @(negedge clk);
    offer(d, 0, 7, 3, 1'b1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; abort = 1'b1;
    #1 check("t5_ready_abort", in_ready, 0);
    @(posedge clk);
    #1 abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_en_after_abort", serial_en, 0);
    check("t5_busy_after_abort", busy, 0);
    check("t5_ready_after_abort", in_ready, 1);
    in_valid = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || frame_start || busy || serial_en != 2'b00) bad++;
    end
    check("t5_idle_no_done", bad, 0);

    // Width saturates to 32 bits, depth to 4 words.
    mon_on = 1'b1;
    d = '{32'h0F0F00FF, 32'hDEADBEEF, 32'h12345678, 32'h80000001};
    @(negedge clk);
    offer(d, 0, 63, 7, 1'b0);
    push_frame(d, 0, 63, 7, 1'b0, 1'b0);
    #1 in_valid = 1'b0;
    drain();
    check("t6_done_delay", done_cyc - fs_cyc, 64);

    // Asynchronous reset mid-frame with a frame held.
    mon_on = 1'b0;
    @(negedge clk);
    offer(d, 0, 63, 7, 1'b1);
    #1 in_valid = 1'b0;
    wait_fs();
    repeat (3) @(negedge clk);
    offer(d, 0, 7, 3, 1'b0);
    #1 in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out", {serial_out, serial_en, frame_start, done, busy}, 0);
    check("t6_rst_counts", {bit_count, slot_count}, 0);
    check("t6_rst_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_start || busy || serial_en != 2'b00) bad++;
    end
    check("t6_held_lost", bad, 0);
    check("sb_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
